tile_config_regfile: RTL

//   Parametrised configuration register file for one PE tile; next generation of the per-tile address matcher.

---
 rtl/tile_config_regfile_if.sv | 25 ++
 rtl/tile_config_regfile.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tile_config_regfile_if.sv
// Configuration request / readback bus for one PE tile.
// The master side issues config requests and consumes readback words;
// the slave side (the tile register file) accepts requests and returns data.
interface tile_config_regfile_if;
  logic        config_valid;
  logic        config_ready;
  logic        config_write;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_lock;
  logic        read_valid;
  logic        read_ready;
  logic [31:0] read_data;
  logic        addr_err;

  modport master (
    output config_valid, config_write, config_addr, config_data, config_lock, read_ready,
    input  config_ready, read_valid, read_data, addr_err
  );

  modport slave (
    input  config_valid, config_write, config_addr, config_data, config_lock, read_ready,
    output config_ready, read_valid, read_data, addr_err
  );
endinterface

// File: rtl/tile_config_regfile.sv
// Per-tile configuration register file.
// Decodes {tile id, reg id} against tile_id, supports addressed and broadcast
// writes, a write lock, and single-outstanding readback over valid/ready.
//
//   state | meaning
//   IDLE  | ready for a request; writes complete here at one per cycle
//   RESP  | holding a readback word until the consumer takes it
module tile_config_regfile #(
  parameter int          NUM_REGS = 4,
  parameter int          REG_W    = 32,
  parameter logic [15:0] BCAST_ID = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               tile_id,
  tile_config_regfile_if.slave      cfg,
  output logic [NUM_REGS-1:0]       config_en,
  output logic [NUM_REGS*REG_W-1:0] config_regs
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [16:0] NUM_REGS_L = 17'(NUM_REGS);

  state_t               state_q, state_d;
  logic [REG_W-1:0]     regs_q [NUM_REGS];
  logic [REG_W-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  config_en_q, config_en_d;
  logic                 read_valid_q, read_valid_d;
  logic [31:0]          read_data_q, read_data_d;
  logic                 addr_err_q, addr_err_d;

  logic                 accept;
  logic [15:0]          tid;
  logic [15:0]          rid;
  logic                 hit;
  logic                 bcast;
  logic                 rid_ok;
  logic                 wr_do;
  logic                 wr_rej;
  logic                 rd_do;
  logic [31:0]          rd_word;

  // Ready only while idle and out of reset, so it drops the instant reset asserts.
  assign cfg.config_ready = (state_q == IDLE) && reset;
  assign cfg.read_valid   = read_valid_q;
  assign cfg.read_data    = read_data_q;
  assign cfg.addr_err     = addr_err_q;
  assign config_en        = config_en_q;

  // Request decode: hit has priority over broadcast, so a tile whose id equals
  // BCAST_ID still serves reads.
  always_comb begin
    accept = cfg.config_valid & cfg.config_ready;
    tid    = cfg.config_addr[31:16];
    rid    = cfg.config_addr[15:0];
    hit    = (tid == tile_id);
    bcast  = (tid == BCAST_ID);
    rid_ok = ({1'b0, rid} < NUM_REGS_L);
    wr_do  = accept & cfg.config_write & (hit | bcast) & rid_ok & ~cfg.config_lock;
    wr_rej = accept & cfg.config_write & hit & (~rid_ok | cfg.config_lock);
    rd_do  = accept & ~cfg.config_write & hit;
  end

  // Register write, update strobes and readback mux; an out-of-range rid selects nothing, so reads return 0.
  always_comb begin
    regs_d      = regs_q;
    config_en_d = '0;
    rd_word     = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rid == 16'(k)) begin
        rd_word = 32'(regs_q[k]);
        if (wr_do) begin
          regs_d[k]      = cfg.config_data[REG_W-1:0];
          config_en_d[k] = 1'b1;
        end
      end
    end
  end

  // Next-state and readback channel; any rejected hit request pulses addr_err for one cycle.
  always_comb begin
    state_d      = state_q;
    read_valid_d = read_valid_q;
    read_data_d  = read_data_q;
    addr_err_d   = wr_rej | (rd_do & ~rid_ok);
    case (state_q)
      IDLE: begin
        if (rd_do) begin
          state_d      = RESP;
          read_valid_d = 1'b1;
          read_data_d  = rd_word;
        end
      end
      RESP: begin
        if (read_valid_q && cfg.read_ready) begin
          state_d      = IDLE;
          read_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registers and pulse outputs; reset drops any pending response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      config_en_q  <= '0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
      addr_err_q   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      config_en_q  <= config_en_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
      addr_err_q   <= addr_err_d;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Flatten the register array onto the config bus; reg k at [k*REG_W +: REG_W].
  always_comb begin
    config_regs = '0;
    for (int k = 0; k < NUM_REGS; k++) config_regs[k*REG_W +: REG_W] = regs_q[k];
  end

endmodule
